// File: rtl/fifo_ctrl_2x10_pkg.sv
// Shared defaults for the 2^10 x 8-bit FIFO control stage.
package fifo_ctrl_2x10_pkg;

    // Address and data width defaults.
    localparam int FIFO_AW       = 10;
    localparam int FIFO_DW       = 8;

    // Watermarks used for the almost-full / almost-empty flags.
    localparam int FIFO_AF_LEVEL = 1020;
    localparam int FIFO_AE_LEVEL = 4;

    // Number of entries for a given address width.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    localparam int FIFO_DEPTH    = fifo_depth(FIFO_AW);

endpackage

// File: rtl/fifo_ctrl_2x10_ptr.sv
// Wrapping AW-bit pointer register with an increment enable.
module fifo_ptr
    import fifo_ctrl_2x10_pkg::*;
#(
    parameter int AW = FIFO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Next pointer: natural AW-bit overflow gives the DEPTH-1 -> 0 wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Pointer register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_2x10.sv
// FIFO control and storage: request arbitration, pointers, data array,
// occupancy count and registered status flags.
//
// Handshake: a write is accepted when wr_en=1 and the registered full flag
// is 0; a read is accepted when rd_en=1 and the registered empty flag is 0.
// Refused requests raise overflow/underflow for exactly one cycle. The word of
// an accepted read appears on rd_data one cycle later, qualified by rd_valid,
// which is high for that single cycle only.
module fifo_ctrl_2x10
    import fifo_ctrl_2x10_pkg::*;
#(
    parameter int AW       = FIFO_AW,
    parameter int DW       = FIFO_DW,
    parameter int AF_LEVEL = FIFO_AF_LEVEL,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam int          DEPTH   = fifo_depth(AW);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          wr_acc;
    logic          rd_acc;

    logic [AW:0]   count_q,     count_d;
    logic          full_q,      full_d;
    logic          empty_q,     empty_d;
    logic          af_q,        af_d;
    logic          ae_q,        ae_d;
    logic          ovf_q,       ovf_d;
    logic          udf_q,       udf_d;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;

    // Acceptance is judged on the registered flags only, so a full FIFO can
    // still take a read and an empty FIFO a write in the same cycle.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (wr_acc),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (rd_acc),
        .ptr_o (rd_ptr)
    );

    // Next count and flags; flags come from the next count so they move on
    // the same edge as count itself.
    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        ovf_d   = wr_en & full_q;
        udf_d   = rd_en & empty_q;
    end

    // Count, flag and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Data array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Synchronous read port: rd_data holds between reads, rd_valid marks the
    // single cycle following an accepted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr];
            end
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
